// File: rtl/qar_i2c_pkg.sv
// ---------------------------------------------------------------------------
// qar_i2c_pkg : controller register map, CMD/STATUS bits, error codes,
//               sequencer states and the per-transaction step ROM.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package qar_i2c_pkg;

   localparam logic [5:0] ADDR_CTRL   = 6'd0;
   localparam logic [5:0] ADDR_CLKDIV = 6'd1;
   localparam logic [5:0] ADDR_STATUS = 6'd2;
   localparam logic [5:0] ADDR_TXDATA = 6'd5;
   localparam logic [5:0] ADDR_RXDATA = 6'd6;
   localparam logic [5:0] ADDR_CMD    = 6'd7;

   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_NACK_BIT = 3;
   localparam int CMD_WRITE_BIT = 2;

   localparam logic [3:0] CMD_NONE  = 4'b0000;
   localparam logic [3:0] CMD_START = 4'b0001;
   localparam logic [3:0] CMD_STOP  = 4'b0010;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b1000;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_NACK    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      S_INIT0  = 4'd0,
      S_INIT1  = 4'd1,
      S_IDLE   = 4'd2,
      S_EXEC   = 4'd3,
      S_SETTLE = 4'd4,
      S_POLL   = 4'd5,
      S_NACK   = 4'd6,
      S_POP    = 4'd7,
      S_RESP   = 4'd8
   } seq_state_t;

   typedef enum logic [1:0] {OP_CMD, OP_PUSH, OP_POP, OP_END} op_kind_t;
   typedef enum logic [1:0] {SEL_DEV_W, SEL_DEV_R, SEL_REG, SEL_WDATA} push_sel_t;

   typedef struct packed {
      op_kind_t  kind;
      logic [3:0] cmd;
      push_sel_t sel;
   } step_t;

   function automatic step_t op_cmd(input logic [3:0] c);
      op_cmd = '{kind: OP_CMD, cmd: c, sel: SEL_DEV_W};
   endfunction

   function automatic step_t op_push(input push_sel_t s);
      op_push = '{kind: OP_PUSH, cmd: CMD_NONE, sel: s};
   endfunction

   function automatic step_t op_other(input op_kind_t k);
      op_other = '{kind: k, cmd: CMD_NONE, sel: SEL_DEV_W};
   endfunction

   function automatic step_t step_rom(input logic rnw, input logic [3:0] idx);
      step_t s;
      s = op_other(OP_END);
      if (!rnw) begin
         case (idx)
            4'd0:    s = op_cmd(CMD_START);
            4'd1:    s = op_push(SEL_DEV_W);
            4'd2:    s = op_cmd(CMD_WRITE);
            4'd3:    s = op_push(SEL_REG);
            4'd4:    s = op_cmd(CMD_WRITE);
            4'd5:    s = op_push(SEL_WDATA);
            4'd6:    s = op_cmd(CMD_WRITE);
            4'd7:    s = op_cmd(CMD_STOP);
            default: s = op_other(OP_END);
         endcase
      end else begin
         case (idx)
            4'd0:    s = op_cmd(CMD_START);
            4'd1:    s = op_push(SEL_DEV_W);
            4'd2:    s = op_cmd(CMD_WRITE);
            4'd3:    s = op_push(SEL_REG);
            4'd4:    s = op_cmd(CMD_WRITE);
            4'd5:    s = op_cmd(CMD_START);
            4'd6:    s = op_push(SEL_DEV_R);
            4'd7:    s = op_cmd(CMD_WRITE);
            4'd8:    s = op_cmd(CMD_READ);
            4'd9:    s = op_other(OP_POP);
            4'd10:   s = op_cmd(CMD_STOP);
            default: s = op_other(OP_END);
         endcase
      end
      return s;
   endfunction

   // Index of the STOP step in each list; a NACK jumps straight there.
   function automatic logic [3:0] stop_step(input logic rnw);
      return rnw ? 4'd10 : 4'd7;
   endfunction

endpackage

`default_nettype wire

// File: rtl/qar_i2c_rr_arb.sv
// ---------------------------------------------------------------------------
// qar_i2c_rr_arb : round-robin arbiter, one-hot grant, pointer moves on accept.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qar_i2c_rr_arb #(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            accept,
   output logic [NREQ-1:0] grant
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   int               rank;
   int               best;
   int               best_rank;

   // Rank each requester by its distance from the pointer; lowest rank wins.
   always_comb begin
      best      = 0;
      best_rank = NREQ;
      rank      = 0;
      grant     = '0;
      ptr_d     = ptr_q;
      for (int j = 0; j < NREQ; j++) begin
         rank = j - int'(ptr_q);
         if (rank < 0) rank = rank + NREQ;
         if (req[j] && (rank < best_rank)) begin
            best_rank = rank;
            best      = j;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         grant[j] = (best_rank < NREQ) && (j == best);
      end
      if (accept && (best_rank < NREQ)) begin
         ptr_d = (best == NREQ - 1) ? '0 : PTR_W'(best + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

`default_nettype wire

// File: rtl/qar_i2c_xfer_seq.sv
// ---------------------------------------------------------------------------
// qar_i2c_xfer_seq : arbitrates single-byte register transactions and runs
//                    them on the qar I2C controller register bus.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qar_i2c_xfer_seq
   import qar_i2c_pkg::*;
#(
   parameter int NREQ         = 2,
   parameter int CLKDIV_INIT  = 100,
   parameter int POLL_TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   req_rnw,
   input  logic [7*NREQ-1:0] req_dev,
   input  logic [8*NREQ-1:0] req_reg,
   input  logic [8*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic [1:0]        rsp_err,
   output logic              busy,
   output logic              m_write,
   output logic              m_read,
   output logic [5:0]        m_addr,
   output logic [31:0]       m_wdata,
   input  logic [31:0]       m_rdata
);

   localparam logic [15:0] POLL_LAST = (POLL_TIMEOUT > 0) ? 16'(POLL_TIMEOUT - 1) : 16'd0;

   seq_state_t  state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic [1:0]  settle_q, settle_d;
   logic [15:0] poll_q, poll_d;
   logic        rnw_q, rnw_d;
   logic [6:0]  dev_q, dev_d;
   logic [7:0]  dreg_q, dreg_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] req_ready_q, req_ready_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_rdata_q, rsp_rdata_d;
   logic [1:0]  rsp_err_q, rsp_err_d;
   logic        busy_q, busy_d;
   logic        m_write_q, m_write_d;
   logic        m_read_q, m_read_d;
   logic [5:0]  m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;

   logic [NREQ-1:0] arb_grant;
   logic            arb_accept;
   step_t           cur;
   logic [7:0]      push_byte;
   logic            unused_rdata;

   assign unused_rdata = ^m_rdata[31:8];

   qar_i2c_rr_arb #(.NREQ(NREQ)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req_valid),
      .accept (arb_accept),
      .grant  (arb_grant)
   );

   assign cur = step_rom(rnw_q, step_q);

   always_comb begin
      case (cur.sel)
         SEL_DEV_W: push_byte = {dev_q, 1'b0};
         SEL_DEV_R: push_byte = {dev_q, 1'b1};
         SEL_REG:   push_byte = dreg_q;
         default:   push_byte = wdata_q;
      endcase
   end

   // Bus strobes are registered: a read issued here is visible next cycle,
   // so the state that follows is the one that samples m_rdata.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      settle_d    = settle_q;
      poll_d      = poll_q;
      rnw_d       = rnw_q;
      dev_d       = dev_q;
      dreg_d      = dreg_q;
      wdata_d     = wdata_q;
      grant_d     = grant_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      busy_d      = busy_q;
      m_write_d   = 1'b0;
      m_read_d    = 1'b0;
      m_addr_d    = '0;
      m_wdata_d   = '0;
      arb_accept  = 1'b0;

      case (state_q)
         S_INIT0: begin
            m_write_d = 1'b1;
            m_addr_d  = ADDR_CLKDIV;
            m_wdata_d = 32'(CLKDIV_INIT);
            state_d   = S_INIT1;
         end
         S_INIT1: begin
            m_write_d = 1'b1;
            m_addr_d  = ADDR_CTRL;
            m_wdata_d = 32'd1;
            state_d   = S_IDLE;
         end
         S_IDLE: begin
            busy_d = 1'b0;
            if (|req_valid) begin
               arb_accept  = 1'b1;
               req_ready_d = arb_grant;
               grant_d     = arb_grant;
               busy_d      = 1'b1;
               rsp_rdata_d = 8'd0;
               rsp_err_d   = ERR_OK;
               step_d      = 4'd0;
               state_d     = S_EXEC;
               for (int i = 0; i < NREQ; i++) begin
                  if (arb_grant[i]) begin
                     rnw_d   = req_rnw[i];
                     dev_d   = req_dev[7*i +: 7];
                     dreg_d  = req_reg[8*i +: 8];
                     wdata_d = req_wdata[8*i +: 8];
                  end
               end
            end
         end
         S_EXEC: begin
            case (cur.kind)
               OP_CMD: begin
                  m_write_d = 1'b1;
                  m_addr_d  = ADDR_CMD;
                  m_wdata_d = {28'd0, cur.cmd};
                  settle_d  = 2'd0;
                  poll_d    = 16'd0;
                  state_d   = S_SETTLE;
               end
               OP_PUSH: begin
                  m_write_d = 1'b1;
                  m_addr_d  = ADDR_TXDATA;
                  m_wdata_d = {24'd0, push_byte};
                  step_d    = step_q + 4'd1;
               end
               OP_POP: begin
                  m_read_d = 1'b1;
                  m_addr_d = ADDR_RXDATA;
                  state_d  = S_POP;
               end
               default: state_d = S_RESP;
            endcase
         end
         S_SETTLE: begin
            // Three quiet cycles after the CMD write before STATUS is trusted.
            if (settle_q == 2'd3) begin
               m_read_d = 1'b1;
               m_addr_d = ADDR_STATUS;
               state_d  = S_POLL;
            end else begin
               settle_d = settle_q + 2'd1;
            end
         end
         S_POLL: begin
            if (!m_rdata[STAT_BUSY_BIT]) begin
               if (cur.cmd[CMD_WRITE_BIT]) begin
                  m_read_d = 1'b1;
                  m_addr_d = ADDR_STATUS;
                  state_d  = S_NACK;
               end else begin
                  step_d  = step_q + 4'd1;
                  state_d = S_EXEC;
               end
            end else if (poll_q >= POLL_LAST) begin
               rsp_err_d = ERR_TIMEOUT;
               state_d   = S_RESP;
            end else begin
               poll_d   = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
               m_read_d = 1'b1;
               m_addr_d = ADDR_STATUS;
            end
         end
         S_NACK: begin
            if (m_rdata[STAT_NACK_BIT]) begin
               m_write_d = 1'b1;
               m_addr_d  = ADDR_STATUS;
               m_wdata_d = 32'h8;
               rsp_err_d = ERR_NACK;
               step_d    = stop_step(rnw_q);
            end else begin
               step_d = step_q + 4'd1;
            end
            state_d = S_EXEC;
         end
         S_POP: begin
            rsp_rdata_d = m_rdata[7:0];
            step_d      = step_q + 4'd1;
            state_d     = S_EXEC;
         end
         S_RESP: begin
            rsp_valid_d = grant_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_INIT0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_INIT0;
         step_q      <= 4'd0;
         settle_q    <= 2'd0;
         poll_q      <= 16'd0;
         rnw_q       <= 1'b0;
         dev_q       <= 7'd0;
         dreg_q      <= 8'd0;
         wdata_q     <= 8'd0;
         grant_q     <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= 8'd0;
         rsp_err_q   <= ERR_OK;
         busy_q      <= 1'b1;
         m_write_q   <= 1'b0;
         m_read_q    <= 1'b0;
         m_addr_q    <= 6'd0;
         m_wdata_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         settle_q    <= settle_d;
         poll_q      <= poll_d;
         rnw_q       <= rnw_d;
         dev_q       <= dev_d;
         dreg_q      <= dreg_d;
         wdata_q     <= wdata_d;
         grant_q     <= grant_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         m_write_q   <= m_write_d;
         m_read_q    <= m_read_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;
   assign m_write   = m_write_q;
   assign m_read    = m_read_q;
   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;

endmodule

`default_nettype wire
